scsi_target_sequencer: RTL and testbench

- Target-side SCSI bus sequencer, directly downstream of the BBC host adapter on the BeebSCSI SCSI bus.
- Consumes the adapter's nSEL, nACK, nRST and nCONF lines and the 8-bit bus it drives.
- Produces nBSY, nREQ, nMSG, CnD, InO and target read data.
- Runs the REQ/ACK byte handshake autonomously and buffers bytes in a FIFO towards the AVR, so firmware handles phases, not individual bytes.

---
 rtl/scsi_target_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_scsi_target_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsi_target_sequencer.sv
// Target-side SCSI bus sequencer for the BeebSCSI bus.
// Runs the REQ/ACK byte handshake without firmware help and buffers bytes in a small
// first-word-fall-through FIFO shared with the AVR. The AVR only sequences phases.
//
// Ports
//   CLK, nCLR                   clock, asynchronous active-low reset
//   scsi_nSEL/nACK/nRST/nCONF   host adapter strobes (active low, asynchronous to CLK)
//   scsi_INTnEXT                1 = internal bus (true data), 0 = external (inverted data)
//   scsi_nDATA_in/out/oe        bus data as sampled / as driven / drive enable
//   scsi_nBSY/nREQ/nMSG/CnD/InO target control lines
//   avr_phase/count/start       phase {MSG,CnD,InO} and byte count, captured on start
//   avr_release                 drop BSY and return to bus free
//   avr_wr/wdata/full           FIFO push side
//   avr_rd/rdata/empty          FIFO pop side, rdata shows the head
//   avr_selected/done/busrst    single-cycle event pulses
//   avr_cfg_data/cfg_valid      configuration byte and its valid pulse
module scsi_target_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic               CLK,
    input  logic               nCLR,
    input  logic               scsi_nSEL,
    input  logic               scsi_nACK,
    input  logic               scsi_nRST,
    input  logic               scsi_nCONF,
    input  logic               scsi_INTnEXT,
    input  logic [7:0]         scsi_nDATA_in,
    output logic [7:0]         scsi_nDATA_out,
    output logic               scsi_nDATA_oe,
    output logic               scsi_nBSY,
    output logic               scsi_nREQ,
    output logic               scsi_nMSG,
    output logic               scsi_CnD,
    output logic               scsi_InO,
    input  logic [2:0]         avr_phase,
    input  logic [COUNT_W-1:0] avr_count,
    input  logic               avr_start,
    input  logic               avr_release,
    input  logic               avr_wr,
    input  logic [7:0]         avr_wdata,
    output logic               avr_full,
    input  logic               avr_rd,
    output logic [7:0]         avr_rdata,
    output logic               avr_empty,
    output logic               avr_selected,
    output logic               avr_done,
    output logic               avr_busrst,
    output logic [7:0]         avr_cfg_data,
    output logic               avr_cfg_valid
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);
    localparam logic [COUNT_W-1:0] LAST_BYTE = COUNT_W'(1);

    typedef enum logic [2:0] {StIdle, StSelected, StSetup, StReq, StAckw} stateE;

    // Two-flop synchronisers for the asynchronous host strobes.
    logic [1:0] selSr, ackSr, rstSr, confSr;
    logic       rstPrev, confPrev;
    logic       selSync, ackSync, rstSync, confSync;
    logic [7:0] busMapped;

    assign selSync   = selSr[1];
    assign ackSync   = ackSr[1];
    assign rstSync   = rstSr[1];
    assign confSync  = confSr[1];
    assign busMapped = scsi_INTnEXT ? scsi_nDATA_in : ~scsi_nDATA_in;

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            selSr         <= 2'b11;
            ackSr         <= 2'b11;
            rstSr         <= 2'b11;
            confSr        <= 2'b11;
            rstPrev       <= 1'b1;
            confPrev      <= 1'b1;
            avr_busrst    <= 1'b0;
            avr_cfg_valid <= 1'b0;
            avr_cfg_data  <= 8'h00;
        end else begin
            selSr         <= {selSr[0], scsi_nSEL};
            ackSr         <= {ackSr[0], scsi_nACK};
            rstSr         <= {rstSr[0], scsi_nRST};
            confSr        <= {confSr[0], scsi_nCONF};
            rstPrev       <= rstSync;
            confPrev      <= confSync;
            avr_busrst    <= rstPrev & ~rstSync;
            avr_cfg_valid <= ~confPrev & confSync;
            // The host latch keeps the byte on the bus after the strobe ends.
            if (~confPrev & confSync) avr_cfg_data <= busMapped;
        end
    end

    // FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   occ;
    logic [7:0]    holdQ, head;
    logic          seqPush, seqPop, flush, doPush, doPop;

    assign head      = mem[rdPtr];
    assign avr_empty = (occ == '0);
    assign avr_full  = (occ == FULL_OCC);
    assign avr_rdata = avr_empty ? holdQ : head;
    assign doPop     = (avr_rd | seqPop) & ~avr_empty & ~flush;
    assign doPush    = (avr_wr | seqPush) & (~avr_full | doPop) & ~flush;

    always_ff @(posedge CLK) begin
        if (doPush) mem[wrPtr] <= seqPush ? busMapped : avr_wdata;
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
            holdQ <= 8'h00;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else begin
            // Keep the last head so rdata holds once the FIFO drains.
            if (!avr_empty) holdQ <= head;
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      occ <= occ + 1'b1;
            else if (doPop && !doPush) occ <= occ - 1'b1;
        end
    end

    // Sequencer
    stateE              stateQ, stateD;
    logic               nReqQ, nReqD, doneD, selectedD;
    logic [7:0]         dataOutQ, dataOutD;
    logic [COUNT_W-1:0] countQ, countD;
    logic [2:0]         phaseQ, phaseD;

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            stateQ       <= StIdle;
            nReqQ        <= 1'b1;
            dataOutQ     <= 8'hFF;
            countQ       <= '0;
            phaseQ       <= 3'b011;
            avr_done     <= 1'b0;
            avr_selected <= 1'b0;
        end else begin
            stateQ       <= stateD;
            nReqQ        <= nReqD;
            dataOutQ     <= dataOutD;
            countQ       <= countD;
            phaseQ       <= phaseD;
            avr_done     <= doneD;
            avr_selected <= selectedD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        nReqD     = nReqQ;
        dataOutD  = dataOutQ;
        countD    = countQ;
        phaseD    = phaseQ;
        doneD     = 1'b0;
        selectedD = 1'b0;
        seqPush   = 1'b0;
        seqPop    = 1'b0;
        flush     = 1'b0;
        if (!rstSync) begin
            stateD = StIdle;
            nReqD  = 1'b1;
            countD = '0;
            flush  = 1'b1;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (!selSync) begin
                        stateD    = StSelected;
                        selectedD = 1'b1;
                    end
                end
                StSelected: begin
                    if (avr_release) begin
                        stateD = StIdle;
                    end else if (avr_start) begin
                        phaseD = avr_phase;
                        countD = avr_count;
                        if (avr_count == '0) doneD = 1'b1;
                        else                 stateD = StSetup;
                    end
                end
                StSetup: begin
                    if (phaseQ[0]) begin
                        if (!avr_full) begin
                            stateD = StReq;
                            nReqD  = 1'b0;
                        end
                    end else if (!avr_empty) begin
                        seqPop   = 1'b1;
                        dataOutD = scsi_INTnEXT ? head : ~head;
                        stateD   = StReq;
                    end
                end
                StReq: begin
                    // Only target-to-host arrives here with nREQ high: one data setup cycle.
                    if (nReqQ) begin
                        nReqD = 1'b0;
                    end else if (!ackSync) begin
                        seqPush = phaseQ[0];
                        nReqD   = 1'b1;
                        stateD  = StAckw;
                    end
                end
                StAckw: begin
                    if (ackSync) begin
                        countD = countQ - 1'b1;
                        if (countQ == LAST_BYTE) begin
                            doneD  = 1'b1;
                            stateD = StSelected;
                        end else begin
                            stateD = StSetup;
                        end
                    end
                end
                default: stateD = StIdle;
            endcase
        end
    end

    logic idle, xfer;
    assign idle = (stateQ == StIdle);
    assign xfer = (stateQ == StSetup) || (stateQ == StReq) || (stateQ == StAckw);

    assign scsi_nBSY      = idle;
    assign scsi_nREQ      = nReqQ;
    assign scsi_nMSG      = idle ? 1'b1 : ~phaseQ[2];
    assign scsi_CnD       = idle ? 1'b1 : phaseQ[1];
    assign scsi_InO       = idle ? 1'b1 : phaseQ[0];
    assign scsi_nDATA_oe  = xfer & ~phaseQ[0];
    assign scsi_nDATA_out = dataOutQ;

endmodule

// File: tb/tb_scsi_target_sequencer.sv
`timescale 1ns/1ps
module tb_scsi_target_sequencer;
    logic        CLK = 1'b0;
    logic        nCLR;
    logic        scsi_nSEL, scsi_nACK, scsi_nRST, scsi_nCONF, scsi_INTnEXT;
    logic [7:0]  scsi_nDATA_in;
    logic [7:0]  scsi_nDATA_out;
    logic        scsi_nDATA_oe, scsi_nBSY, scsi_nREQ, scsi_nMSG, scsi_CnD, scsi_InO;
    logic [2:0]  avr_phase;
    logic [15:0] avr_count;
    logic        avr_start, avr_release, avr_wr, avr_rd;
    logic [7:0]  avr_wdata, avr_rdata, avr_cfg_data;
    logic        avr_full, avr_empty, avr_selected, avr_done, avr_busrst, avr_cfg_valid;

    int nChecks = 0;
    int nErrors = 0;

    always #5 CLK = ~CLK;

    scsi_target_sequencer #(.FIFO_DEPTH(4), .COUNT_W(16)) dut (
        .CLK(CLK), .nCLR(nCLR),
        .scsi_nSEL(scsi_nSEL), .scsi_nACK(scsi_nACK), .scsi_nRST(scsi_nRST),
        .scsi_nCONF(scsi_nCONF), .scsi_INTnEXT(scsi_INTnEXT),
        .scsi_nDATA_in(scsi_nDATA_in), .scsi_nDATA_out(scsi_nDATA_out),
        .scsi_nDATA_oe(scsi_nDATA_oe), .scsi_nBSY(scsi_nBSY), .scsi_nREQ(scsi_nREQ),
        .scsi_nMSG(scsi_nMSG), .scsi_CnD(scsi_CnD), .scsi_InO(scsi_InO),
        .avr_phase(avr_phase), .avr_count(avr_count), .avr_start(avr_start),
        .avr_release(avr_release), .avr_wr(avr_wr), .avr_wdata(avr_wdata),
        .avr_full(avr_full), .avr_rd(avr_rd), .avr_rdata(avr_rdata),
        .avr_empty(avr_empty), .avr_selected(avr_selected), .avr_done(avr_done),
        .avr_busrst(avr_busrst), .avr_cfg_data(avr_cfg_data), .avr_cfg_valid(avr_cfg_valid)
    );

    // Event counters for the single-cycle pulses and nREQ falling edges.
    int   doneCnt = 0, selCnt = 0, busrstCnt = 0, cfgCnt = 0, reqCnt = 0;
    logic reqPrev = 1'b1;
    always @(negedge CLK) begin
        if (avr_done)      doneCnt   <= doneCnt + 1;
        if (avr_selected)  selCnt    <= selCnt + 1;
        if (avr_busrst)    busrstCnt <= busrstCnt + 1;
        if (avr_cfg_valid) cfgCnt    <= cfgCnt + 1;
        if (!scsi_nREQ && reqPrev) reqCnt <= reqCnt + 1;
        reqPrev <= scsi_nREQ;
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pushByte(input logic [7:0] d);
        avr_wdata = d;
        avr_wr    = 1'b1;
        @(negedge CLK);
        avr_wr    = 1'b0;
    endtask

    task automatic popByte();
        avr_rd = 1'b1;
        @(negedge CLK);
        avr_rd = 1'b0;
    endtask

    task automatic startPhase(input logic [2:0] p, input logic [15:0] c);
        avr_phase = p;
        avr_count = c;
        avr_start = 1'b1;
        @(negedge CLK);
        avr_start = 1'b0;
    endtask

    task automatic selectTarget(input string tag);
        scsi_nSEL = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (!scsi_nBSY) break;
        end
        checkEq(tag, scsi_nBSY, 1'b0);
        scsi_nSEL = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    // Host side of one byte: wait for REQ, answer with ACK, wait for REQ to clear.
    task automatic hostByte(input logic [7:0] drive, input int maxWait,
                            output logic [7:0] prevData, output logic prevOe, output bit ok);
        ok       = 1'b0;
        prevData = scsi_nDATA_out;
        prevOe   = scsi_nDATA_oe;
        for (int i = 0; i < maxWait; i++) begin
            @(negedge CLK);
            if (!scsi_nREQ) begin
                ok = 1'b1;
                break;
            end
            prevData = scsi_nDATA_out;
            prevOe   = scsi_nDATA_oe;
        end
        if (ok) begin
            scsi_nDATA_in = drive;
            scsi_nACK     = 1'b0;
            ok            = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge CLK);
                if (scsi_nREQ) begin
                    ok = 1'b1;
                    break;
                end
            end
            scsi_nACK = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pd;
        logic       po;
        bit         ok;
        int         firstLow, snapA, snapB, snapC;

        nCLR = 1'b0;
        scsi_nSEL = 1'b1; scsi_nACK = 1'b1; scsi_nRST = 1'b1; scsi_nCONF = 1'b1;
        scsi_INTnEXT = 1'b0; scsi_nDATA_in = 8'hFF;
        avr_phase = 3'b000; avr_count = '0; avr_start = 1'b0; avr_release = 1'b0;
        avr_wr = 1'b0; avr_wdata = 8'h00; avr_rd = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        checkEq("rst_lines", {scsi_nBSY, scsi_nREQ, scsi_nMSG, scsi_CnD, scsi_InO, scsi_nDATA_oe},
                6'b111110);
        checkEq("rst_data", scsi_nDATA_out, 8'hFF);
        checkEq("rst_fifo", {avr_empty, avr_full}, 2'b10);
        checkEq("rst_pulses", {avr_selected, avr_done, avr_busrst, avr_cfg_valid}, 4'b0000);
        checkEq("rst_cfg", avr_cfg_data, 8'h00);
        nCLR = 1'b1;
        repeat (2) @(negedge CLK);

        // Selection: BSY on the 3rd edge, one selected pulse, release drops BSY
        snapA = selCnt;
        firstLow = 0;
        scsi_nSEL = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (!scsi_nBSY && firstLow == 0) firstLow = i;
        end
        checkEq("sel_edge", firstLow, 3);
        scsi_nSEL = 1'b1;
        repeat (3) @(negedge CLK);
        checkEq("sel_pulses", selCnt - snapA, 1);
        avr_release = 1'b1;
        @(negedge CLK);
        avr_release = 1'b0;
        checkEq("release_bsy", scsi_nBSY, 1'b1);

        // Target to host, external bus: data inverted on the wire
        scsi_INTnEXT = 1'b0;
        pushByte(8'hA5);
        pushByte(8'h3C);
        selectTarget("t2_sel");
        snapA = doneCnt;
        startPhase(3'b000, 16'd2);
        checkEq("t2_phase", {scsi_nMSG, scsi_CnD, scsi_InO}, 3'b100);
        hostByte(8'h00, 20, pd, po, ok);
        checkEq("t2_b1_ok", ok, 1'b1);
        checkEq("t2_b1_data", {po, pd}, {1'b1, 8'h5A});
        hostByte(8'h00, 20, pd, po, ok);
        checkEq("t2_b2_ok", ok, 1'b1);
        checkEq("t2_b2_data", {po, pd}, {1'b1, 8'hC3});
        repeat (8) @(negedge CLK);
        checkEq("t2_done", doneCnt - snapA, 1);
        checkEq("t2_oe_after", scsi_nDATA_oe, 1'b0);
        checkEq("t2_selected", scsi_nBSY, 1'b0);

        // Host to target, internal bus
        scsi_INTnEXT = 1'b1;
        snapA = doneCnt;
        startPhase(3'b011, 16'd3);
        checkEq("t3_phase", {scsi_nMSG, scsi_CnD, scsi_InO}, 3'b111);
        for (int i = 1; i <= 3; i++) begin
            hostByte(8'(i), 20, pd, po, ok);
            checkEq("t3_byte_ok", ok, 1'b1);
        end
        repeat (8) @(negedge CLK);
        checkEq("t3_done", doneCnt - snapA, 1);
        for (int i = 1; i <= 3; i++) begin
            checkEq("t3_rdata", {avr_empty, avr_rdata}, {1'b0, 8'(i)});
            popByte();
        end
        checkEq("t3_empty", avr_empty, 1'b1);

        // Backpressure: FIFO of 4 stalls REQ until the AVR pops one
        startPhase(3'b001, 16'd6);
        for (int i = 0; i < 4; i++) begin
            hostByte(8'h10 + 8'(i), 20, pd, po, ok);
            checkEq("t4_byte_ok", ok, 1'b1);
        end
        hostByte(8'hEE, 20, pd, po, ok);
        checkEq("t4_stall", ok, 1'b0);
        checkEq("t4_full", avr_full, 1'b1);
        popByte();
        hostByte(8'h14, 20, pd, po, ok);
        checkEq("t4_one_more", ok, 1'b1);
        hostByte(8'hEE, 20, pd, po, ok);
        checkEq("t4_stall2", ok, 1'b0);
        checkEq("t4_head", avr_rdata, 8'h11);
        scsi_nRST = 1'b0;
        repeat (5) @(negedge CLK);
        scsi_nRST = 1'b1;
        repeat (4) @(negedge CLK);

        // Bus reset during REQ of a target-to-host transfer
        scsi_INTnEXT = 1'b0;
        pushByte(8'h66);
        pushByte(8'h77);
        selectTarget("t5_sel");
        startPhase(3'b000, 16'd3);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (!scsi_nREQ) begin
                ok = 1'b1;
                break;
            end
        end
        checkEq("t5_req", ok, 1'b1);
        checkEq("t5_drive", {scsi_nDATA_oe, scsi_nDATA_out}, {1'b1, 8'h99});
        snapB = busrstCnt;
        scsi_nRST = 1'b0;
        repeat (3) @(negedge CLK);
        checkEq("t5_lines", {scsi_nREQ, scsi_nBSY, scsi_nDATA_oe, avr_empty}, 4'b1101);
        repeat (2) @(negedge CLK);
        snapA = selCnt;
        scsi_nSEL = 1'b0;
        repeat (8) @(negedge CLK);
        checkEq("t5_no_sel", {scsi_nBSY, 8'(selCnt - snapA)}, {1'b1, 8'd0});
        checkEq("t5_busrst", busrstCnt - snapB, 1);
        scsi_nSEL = 1'b1;
        repeat (4) @(negedge CLK);
        scsi_nRST = 1'b1;
        repeat (4) @(negedge CLK);

        // Configuration byte, external then internal
        snapC = cfgCnt;
        scsi_INTnEXT = 1'b0;
        scsi_nDATA_in = 8'h7E;
        scsi_nCONF = 1'b0;
        repeat (4) @(negedge CLK);
        scsi_nCONF = 1'b1;
        repeat (5) @(negedge CLK);
        checkEq("cfg_ext", avr_cfg_data, 8'h81);
        checkEq("cfg_valid", cfgCnt - snapC, 1);
        scsi_INTnEXT = 1'b1;
        scsi_nDATA_in = 8'h3C;
        scsi_nCONF = 1'b0;
        repeat (4) @(negedge CLK);
        scsi_nCONF = 1'b1;
        repeat (5) @(negedge CLK);
        checkEq("cfg_int", avr_cfg_data, 8'h3C);

        // Zero count: done at once, no REQ
        selectTarget("t6_sel");
        snapA = doneCnt;
        snapB = reqCnt;
        startPhase(3'b000, 16'd0);
        checkEq("t6_done_now", avr_done, 1'b1);
        repeat (6) @(negedge CLK);
        checkEq("t6_done_once", doneCnt - snapA, 1);
        checkEq("t6_no_req", reqCnt - snapB, 0);
        checkEq("t6_still_sel", scsi_nBSY, 1'b0);
        avr_release = 1'b1;
        @(negedge CLK);
        avr_release = 1'b0;

        // FIFO limits: push when full dropped, pop when empty holds, push+pop together
        for (int i = 0; i < 5; i++) pushByte(8'h21 + 8'(i));
        checkEq("ff_full", avr_full, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkEq("ff_order", avr_rdata, 8'h21 + 8'(i));
            popByte();
        end
        checkEq("ff_empty", avr_empty, 1'b1);
        popByte();
        checkEq("ff_hold", {avr_empty, avr_rdata}, {1'b1, 8'h24});
        pushByte(8'h30);
        avr_wdata = 8'h31;
        avr_wr = 1'b1;
        avr_rd = 1'b1;
        @(negedge CLK);
        avr_wr = 1'b0;
        avr_rd = 1'b0;
        checkEq("ff_pushpop", {avr_empty, avr_rdata}, {1'b0, 8'h31});
        popByte();
        checkEq("ff_empty2", avr_empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
